dlart_multi: RTL and testbench
==============================

Name: dlart_multi

Overview:
- N-channel DL11-compatible serial line unit (DLART) sitting between the DCJ11 bus capture logic and the TangNano host/ODT link.
- Each channel exposes RCSR/RBUF/XCSR/XBUF to the CPU.
- Each channel has parametrised RX and TX FIFOs and a valid/ready byte stream toward the host.
- Generates per-channel level interrupt requests; replaces the single hard-wired console with unbuffered rrdy/rstb strobes.

Parameters:
- NCHAN, 1: number of channels (1..8).
- RX_DEPTH, 4: RX FIFO entries per channel; power of 2, ≥2.
- TX_DEPTH, 4: TX FIFO entries per channel; power of 2, ≥2.
- BASE0, 22'o17777560: channel 0 register base (console).
- BASE1, 22'o17776500: channel i≥1 base = BASE1 + 8*(i-1).

Ports:
- clk  in  1  single clock for all logic.
- rst  in  1  asynchronous active-high reset.
- bus_req  in  1  one-cycle register access strobe.
- bus_we  in  1  1=write, 0=read.
- bus_byte  in  1  byte write (low byte only used).
- bus_addr  in  22  physical address.
- bus_wdata  in  16  write data.
- bus_init  in  1  one-cycle RESET/INIT pulse.
- bus_hit  out  1  combinational: bus_addr decodes to any channel register.
- bus_rdata  out  16  read data, registered.
- bus_rvalid  out  1  read data valid, one cycle after bus_req&!bus_we&bus_hit.
- host_rx_data  in  8*NCHAN  host→CPU bytes.
- host_rx_valid  in  NCHAN  byte offered.
- host_rx_ready  out  NCHAN  = RX FIFO not full.
- host_tx_data  out  8*NCHAN  CPU→host bytes (FIFO head).
- host_tx_valid  out  NCHAN  = TX FIFO not empty.
- host_tx_ready  in  NCHAN  host accepts.
- irq_rx  out  NCHAN  RIE & RX DONE.
- irq_tx  out  NCHAN  TIE & TX READY.

Behaviour:
- Reset (rst high, async): all FIFOs empty; RIE=TIE=0; bus_rdata=0, bus_rvalid=0; host_tx_valid=0; host_rx_ready=1; irq_rx=0; irq_tx=0.
- bus_init: same clearing as rst, synchronous, one cycle.
- Decode: offsets 0=RCSR, 2=RBUF, 4=XCSR, 6=XBUF; bus_addr[0] ignored; no hit → no effect, bus_rvalid stays 0.
- RCSR:
  - bit7 DONE = RX non-empty (RO).
  - bit6 RIE (RW).
  - Other bits read 0.
- RBUF:
  - bits 7:0 = RX head; bits 15:8 = 0.
  - Read pops one entry; read while empty returns 0 and does not pop.
  - Writes ignored.
- XCSR:
  - bit7 READY = TX not full (RO).
  - bit6 TIE (RW).
  - bit2 MAINT, only with the optional feature; otherwise reads 0.
- XBUF:
  - Write (word or byte) pushes bus_wdata[7:0]; dropped silently if TX full.
  - Reads return 0.
- Read latency: bus_rdata and bus_rvalid are registered one cycle. Pop and DONE update occur in that same edge.
- Host RX push: on host_rx_valid&host_rx_ready. The host is never overrun; ready is deasserted when full.
- Host TX pop: on host_tx_valid&host_tx_ready.
- Simultaneous push and pop on one FIFO in the same cycle:
  - FIFO full: both occur, count unchanged.
  - FIFO empty: push only.
- Pointers wrap modulo DEPTH; count width is clog2(DEPTH)+1.
- Interrupts are level outputs, combinational from registered state; asserting RIE while DONE=1 raises irq_rx in the next cycle.
- Channels are fully independent; at most one bus access per cycle.

Optional Feature:
- Macro: DLART_MAINT_EN.
- Defined: XCSR bit2 MAINT is RW, cleared by rst/bus_init.
  - While MAINT=1, XBUF writes go to that channel's RX FIFO (dropped if full).
  - host_tx_valid is forced 0 and host_rx_ready forced 0 for that channel.
  - TX READY reflects RX-not-full.
- Undefined: bit2 reads 0, writes ignored, no loopback logic.

Decomposition:
- Package dlart_pkg: register offset constants, CSR bit indices (DONE=7, IE=6, MAINT=2), BASE defaults, reg_sel_t enum {RCSR, RBUF, XCSR, XBUF}.
- Sub-module dlart_fifo: parametrised width and depth synchronous FIFO; async rst plus sync clear; exposes full, empty, head.
- dlart_multi instantiates 2*NCHAN dlart_fifo instances plus decode and CSR logic.

Test Plan:
- Reset, then read 17777560 and 17777564 → RCSR=0o000000, XCSR=0o000200, bus_rvalid one cycle later.
- Write XBUF=0x41 on ch0 with host_tx_ready=0 → host_tx_valid=1, data 0x41; 4 more writes → 5th dropped, XCSR=0; host_tx_ready=1 → 0x41..0x44 drained in order.
- Host pushes 4 bytes on ch1 (BASE1) → host_rx_ready=0 after 4th; RBUF reads return bytes in order; 5th read returns 0, RCSR=0.
- Write RCSR=0o100 with RX empty → irq_rx=0; host pushes 0x55 → irq_rx=1 next cycle; read RBUF → irq_rx=0.
- Fill both FIFOs, set TIE, pulse bus_init → all FIFOs empty, RIE=TIE=0, irq_tx=0.
- With DLART_MAINT_EN: set XCSR=0o004, write XBUF=0x7E → host_tx_valid stays 0, RCSR DONE=1, RBUF=0x7E.

Source files
------------

// File: rtl/dlart_pkg.sv
// Shared constants, register selector type and base-address helper for the
// multi-channel DL11-compatible line unit.
package dlart_pkg;

    localparam logic [2:0] OffRcsr = 3'd0;
    localparam logic [2:0] OffRbuf = 3'd2;
    localparam logic [2:0] OffXcsr = 3'd4;
    localparam logic [2:0] OffXbuf = 3'd6;

    localparam int unsigned DoneBit  = 7;
    localparam int unsigned IeBit    = 6;
    localparam int unsigned MaintBit = 2;

    localparam logic [21:0] Base0Default = 22'o17777560;
    localparam logic [21:0] Base1Default = 22'o17776500;

    typedef enum logic [1:0] {
        RCSR = 2'd0,
        RBUF = 2'd1,
        XCSR = 2'd2,
        XBUF = 2'd3
    } reg_sel_t;

    // Channel 0 is the console; the rest are packed 8 bytes apart from base1.
    function automatic logic [21:0] chan_base(input int unsigned ch, input logic [21:0] base0,
                                              input logic [21:0] base1);
        return (ch == 0) ? base0 : base1 + 22'(8 * (ch - 1));
    endfunction

endpackage

// File: rtl/dlart_multi_if.sv
// CPU register-access bus between the DCJ11 capture logic (master) and the
// line unit (slave).
interface dlart_multi_if;

    logic        bus_req;
    logic        bus_we;
    logic        bus_byte;
    logic [21:0] bus_addr;
    logic [15:0] bus_wdata;
    logic        bus_init;
    logic        bus_hit;
    logic [15:0] bus_rdata;
    logic        bus_rvalid;

    modport master (
        output bus_req, bus_we, bus_byte, bus_addr, bus_wdata, bus_init,
        input  bus_hit, bus_rdata, bus_rvalid
    );

    modport slave (
        input  bus_req, bus_we, bus_byte, bus_addr, bus_wdata, bus_init,
        output bus_hit, bus_rdata, bus_rvalid
    );

endinterface

// File: rtl/dlart_fifo.sv
// Synchronous FIFO with async reset and sync clear; a push into a full FIFO
// is accepted only when a pop happens in the same cycle.
module dlart_fifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [Width-1:0] wdata_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [Width-1:0] head_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = PtrW + 1;

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wptr_q, rptr_q;
    logic [CntW-1:0]  cnt_q;
    logic             do_push, do_pop;

    assign full_o  = (cnt_q == CntW'(Depth));
    assign empty_o = (cnt_q == '0);
    assign head_o  = mem_q[rptr_q];

    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else if (clr_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + PtrW'(1);
            if (do_pop)  rptr_q <= rptr_q + PtrW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + CntW'(1);
                2'b01:   cnt_q <= cnt_q - CntW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q] <= wdata_i;
    end

endmodule

// File: rtl/dlart_multi.sv
// N-channel DL11-compatible serial line unit with per-channel RX/TX FIFOs and
// host byte streams. Optional maintenance loopback: define DLART_MAINT_EN.
module dlart_multi
    import dlart_pkg::*;
#(
    parameter int unsigned NCHAN    = 1,
    parameter int unsigned RX_DEPTH = 4,
    parameter int unsigned TX_DEPTH = 4,
    parameter logic [21:0] BASE0    = Base0Default,
    parameter logic [21:0] BASE1    = Base1Default
) (
    input  logic               clk,
    input  logic               rst,
    dlart_multi_if.slave       bus,
    input  logic [8*NCHAN-1:0] host_rx_data,
    input  logic [NCHAN-1:0]   host_rx_valid,
    output logic [NCHAN-1:0]   host_rx_ready,
    output logic [8*NCHAN-1:0] host_tx_data,
    output logic [NCHAN-1:0]   host_tx_valid,
    input  logic [NCHAN-1:0]   host_tx_ready,
    output logic [NCHAN-1:0]   irq_rx,
    output logic [NCHAN-1:0]   irq_tx
);

    logic [NCHAN-1:0] hit_vec;
    reg_sel_t         sel_reg;
    logic             rd_acc, wr_acc;
    logic [21:0]      base;

    logic [NCHAN-1:0] rx_full, rx_empty, tx_full, tx_empty;
    logic [NCHAN-1:0] rx_push, rx_pop, tx_push, tx_pop;
    logic [NCHAN-1:0] maint, tx_ready;
    logic [7:0]       rx_head  [NCHAN];
    logic [7:0]       rx_wdata [NCHAN];
    logic [7:0]       tx_head  [NCHAN];

    logic [NCHAN-1:0] rie_q, tie_q;
    logic [15:0]      rdata_q, rd_mux;
    logic             rvalid_q;

    logic unused_bits;
    assign unused_bits = ^{bus.bus_byte, bus.bus_wdata[15:8], bus.bus_addr[0]};

    always_comb begin
        hit_vec = '0;
        base    = '0;
        for (int unsigned i = 0; i < NCHAN; i++) begin
            base       = chan_base(i, BASE0, BASE1);
            hit_vec[i] = (bus.bus_addr[21:3] == base[21:3]);
        end
    end

    assign sel_reg        = reg_sel_t'(bus.bus_addr[2:1]);
    assign bus.bus_hit    = |hit_vec;
    assign rd_acc         = bus.bus_req & ~bus.bus_we & bus.bus_hit;
    assign wr_acc         = bus.bus_req & bus.bus_we & bus.bus_hit;
    assign bus.bus_rdata  = rdata_q;
    assign bus.bus_rvalid = rvalid_q;

    for (genvar g = 0; g < NCHAN; g++) begin : g_chan
        logic xbuf_wr;

        assign xbuf_wr    = wr_acc & hit_vec[g] & (sel_reg == XBUF);
        assign rx_pop[g]  = rd_acc & hit_vec[g] & (sel_reg == RBUF);
        assign tx_push[g] = xbuf_wr & ~maint[g];
        // In loopback the CPU's own XBUF writes feed the receiver.
        assign rx_push[g]  = maint[g] ? xbuf_wr : (host_rx_valid[g] & host_rx_ready[g]);
        assign rx_wdata[g] = maint[g] ? bus.bus_wdata[7:0] : host_rx_data[8*g +: 8];
        assign tx_pop[g]   = host_tx_valid[g] & host_tx_ready[g];

        assign host_rx_ready[g]        = ~rx_full[g] & ~maint[g];
        assign host_tx_valid[g]        = ~tx_empty[g] & ~maint[g];
        assign host_tx_data[8*g +: 8]  = tx_head[g];
        assign tx_ready[g]             = maint[g] ? ~rx_full[g] : ~tx_full[g];
        assign irq_rx[g]               = rie_q[g] & ~rx_empty[g];
        assign irq_tx[g]               = tie_q[g] & tx_ready[g];

        dlart_fifo #(
            .Width (8),
            .Depth (RX_DEPTH)
        ) u_rx_fifo (
            .clk_i   (clk),
            .rst_i   (rst),
            .clr_i   (bus.bus_init),
            .push_i  (rx_push[g]),
            .pop_i   (rx_pop[g]),
            .wdata_i (rx_wdata[g]),
            .full_o  (rx_full[g]),
            .empty_o (rx_empty[g]),
            .head_o  (rx_head[g])
        );

        dlart_fifo #(
            .Width (8),
            .Depth (TX_DEPTH)
        ) u_tx_fifo (
            .clk_i   (clk),
            .rst_i   (rst),
            .clr_i   (bus.bus_init),
            .push_i  (tx_push[g]),
            .pop_i   (tx_pop[g]),
            .wdata_i (bus.bus_wdata[7:0]),
            .full_o  (tx_full[g]),
            .empty_o (tx_empty[g]),
            .head_o  (tx_head[g])
        );
    end

    always_comb begin
        rd_mux = '0;
        for (int unsigned i = 0; i < NCHAN; i++) begin
            if (hit_vec[i]) begin
                case (sel_reg)
                    RCSR: begin
                        rd_mux[DoneBit] = ~rx_empty[i];
                        rd_mux[IeBit]   = rie_q[i];
                    end
                    RBUF: rd_mux[7:0] = rx_empty[i] ? 8'h00 : rx_head[i];
                    XCSR: begin
                        rd_mux[DoneBit]  = tx_ready[i];
                        rd_mux[IeBit]    = tie_q[i];
                        rd_mux[MaintBit] = maint[i];
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            rie_q    <= '0;
            tie_q    <= '0;
        end else if (bus.bus_init) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            rie_q    <= '0;
            tie_q    <= '0;
        end else begin
            rvalid_q <= rd_acc;
            if (rd_acc) rdata_q <= rd_mux;
            for (int unsigned i = 0; i < NCHAN; i++) begin
                if (wr_acc && hit_vec[i] && sel_reg == RCSR) rie_q[i] <= bus.bus_wdata[IeBit];
                if (wr_acc && hit_vec[i] && sel_reg == XCSR) tie_q[i] <= bus.bus_wdata[IeBit];
            end
        end
    end

`ifdef DLART_MAINT_EN
    logic [NCHAN-1:0] maint_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            maint_q <= '0;
        end else if (bus.bus_init) begin
            maint_q <= '0;
        end else begin
            for (int unsigned i = 0; i < NCHAN; i++) begin
                if (wr_acc && hit_vec[i] && sel_reg == XCSR) maint_q[i] <= bus.bus_wdata[MaintBit];
            end
        end
    end

    assign maint = maint_q;
`else
    assign maint = '0;
`endif

endmodule

// File: tb/tb_dlart_multi.sv
// Self-checking bench for dlart_multi: directed scenarios plus a randomized
// phase, all compared against a queue-based model of the register behaviour.
module tb_dlart_multi;

    localparam int unsigned NCH = 2;
    localparam int unsigned RxD = 4;
    localparam int unsigned TxD = 4;
`ifdef DLART_MAINT_EN
    localparam bit MaintEn = 1'b1;
`else
    localparam bit MaintEn = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    dlart_multi_if bus_if ();

    logic [8*NCH-1:0] host_rx_data;
    logic [NCH-1:0]   host_rx_valid;
    logic [NCH-1:0]   host_rx_ready;
    logic [8*NCH-1:0] host_tx_data;
    logic [NCH-1:0]   host_tx_valid;
    logic [NCH-1:0]   host_tx_ready;
    logic [NCH-1:0]   irq_rx;
    logic [NCH-1:0]   irq_tx;

    dlart_multi #(
        .NCHAN    (NCH),
        .RX_DEPTH (RxD),
        .TX_DEPTH (TxD)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus_if),
        .host_rx_data  (host_rx_data),
        .host_rx_valid (host_rx_valid),
        .host_rx_ready (host_rx_ready),
        .host_tx_data  (host_tx_data),
        .host_tx_valid (host_tx_valid),
        .host_tx_ready (host_tx_ready),
        .irq_rx        (irq_rx),
        .irq_tx        (irq_tx)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state
    byte unsigned rx_q [NCH][$];
    byte unsigned tx_q [NCH][$];
    bit           rie  [NCH];
    bit           tie  [NCH];
    bit           maint[NCH];
    bit           exp_rvalid;
    logic [15:0]  exp_rdata;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [21:0] base_of(input int c);
        return (c == 0) ? 22'o17777560 : 22'o17776500 + 22'(8 * (c - 1));
    endfunction

    function automatic int chan_of(input logic [21:0] a);
        for (int c = 0; c < NCH; c++) begin
            if ((a & ~22'o7) == base_of(c)) return c;
        end
        return -1;
    endfunction

    function automatic logic [15:0] read_val(input int c, input int r);
        bit ready;
        ready = maint[c] ? (rx_q[c].size() < RxD) : (tx_q[c].size() < TxD);
        case (r)
            0: return {8'h00, rx_q[c].size() != 0, rie[c], 6'h00};
            1: return (rx_q[c].size() != 0) ? {8'h00, rx_q[c][0]} : 16'h0000;
            2: return {8'h00, ready, tie[c], 3'b000, maint[c], 2'b00};
            default: return 16'h0000;
        endcase
    endfunction

    task automatic check_outputs();
        logic [NCH-1:0] e_rr, e_tv, e_ir, e_it;
        for (int c = 0; c < NCH; c++) begin
            e_rr[c] = !maint[c] && rx_q[c].size() < RxD;
            e_tv[c] = !maint[c] && tx_q[c].size() > 0;
            e_ir[c] = rie[c] && rx_q[c].size() > 0;
            e_it[c] = tie[c] && (maint[c] ? rx_q[c].size() < RxD : tx_q[c].size() < TxD);
        end
        check_eq("bus_rvalid", bus_if.bus_rvalid, exp_rvalid);
        if (exp_rvalid) check_eq("bus_rdata", bus_if.bus_rdata, exp_rdata);
        check_eq("host_rx_ready", host_rx_ready, e_rr);
        check_eq("host_tx_valid", host_tx_valid, e_tv);
        check_eq("irq_rx", irq_rx, e_ir);
        check_eq("irq_tx", irq_tx, e_it);
        for (int c = 0; c < NCH; c++) begin
            if (e_tv[c]) check_eq("host_tx_data", host_tx_data[8*c +: 8], tx_q[c][0]);
        end
    endtask

    // Drive one cycle of stimulus from a negedge, advance the model, check after the edge.
    task automatic cycle(input bit req, input bit we, input logic [21:0] addr,
                         input logic [15:0] wdata, input logic [NCH-1:0] rxv,
                         input logic [8*NCH-1:0] rxd, input logic [NCH-1:0] txr, input bit init);
        int hc;
        int r;
        bit rx_rdy[NCH];
        bit tx_vld[NCH];
        bus_if.bus_req   = req;
        bus_if.bus_we    = we;
        bus_if.bus_byte  = 1'($urandom_range(0, 1));
        bus_if.bus_addr  = addr;
        bus_if.bus_wdata = wdata;
        bus_if.bus_init  = init;
        host_rx_valid    = rxv;
        host_rx_data     = rxd;
        host_tx_ready    = txr;
        hc = chan_of(addr);
        r  = int'(addr[2:1]);
        #1;
        check_eq("bus_hit", bus_if.bus_hit, hc >= 0);
        if (init) begin
            for (int c = 0; c < NCH; c++) begin
                rx_q[c].delete();
                tx_q[c].delete();
                rie[c]   = 1'b0;
                tie[c]   = 1'b0;
                maint[c] = 1'b0;
            end
            exp_rvalid = 1'b0;
            exp_rdata  = 16'h0000;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                rx_rdy[c] = !maint[c] && rx_q[c].size() < RxD;
                tx_vld[c] = !maint[c] && tx_q[c].size() > 0;
            end
            exp_rvalid = req && !we && hc >= 0;
            if (exp_rvalid) exp_rdata = read_val(hc, r);
            for (int c = 0; c < NCH; c++) begin
                if (txr[c] && tx_vld[c]) void'(tx_q[c].pop_front());
            end
            if (exp_rvalid && r == 1 && rx_q[hc].size() > 0) void'(rx_q[hc].pop_front());
            for (int c = 0; c < NCH; c++) begin
                if (rxv[c] && rx_rdy[c]) rx_q[c].push_back(rxd[8*c +: 8]);
            end
            if (req && we && hc >= 0) begin
                case (r)
                    0: rie[hc] = wdata[6];
                    2: begin
                        tie[hc] = wdata[6];
                        if (MaintEn) maint[hc] = wdata[2];
                    end
                    3: begin
                        if (maint[hc]) begin
                            if (rx_q[hc].size() < RxD) rx_q[hc].push_back(wdata[7:0]);
                        end else if (tx_q[hc].size() < TxD) begin
                            tx_q[hc].push_back(wdata[7:0]);
                        end
                    end
                    default: ;
                endcase
            end
        end
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic rd(input int c, input int r);
        cycle(1'b1, 1'b0, base_of(c) + 22'(2 * r), 16'h0000, '0, '0, '0, 1'b0);
    endtask

    task automatic wr(input int c, input int r, input logic [15:0] d);
        cycle(1'b1, 1'b1, base_of(c) + 22'(2 * r), d, '0, '0, '0, 1'b0);
    endtask

    task automatic hpush(input int c, input logic [7:0] d);
        logic [NCH-1:0]   v;
        logic [8*NCH-1:0] dd;
        v  = '0;
        dd = '0;
        v[c]          = 1'b1;
        dd[8*c +: 8]  = d;
        cycle(1'b0, 1'b0, 22'h0, 16'h0000, v, dd, '0, 1'b0);
    endtask

    initial begin
        byte unsigned vals[4];
        logic [21:0]  a;
        int           c;
        int           r;

        bus_if.bus_req   = 1'b0;
        bus_if.bus_we    = 1'b0;
        bus_if.bus_byte  = 1'b0;
        bus_if.bus_addr  = '0;
        bus_if.bus_wdata = '0;
        bus_if.bus_init  = 1'b0;
        host_rx_data     = '0;
        host_rx_valid    = '0;
        host_tx_ready    = '0;
        for (int i = 0; i < NCH; i++) begin
            rie[i]   = 1'b0;
            tie[i]   = 1'b0;
            maint[i] = 1'b0;
        end
        exp_rvalid = 1'b0;
        exp_rdata  = 16'h0000;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_eq("reset_rdata", bus_if.bus_rdata, 16'h0000);
        check_outputs();

        // Reset-state register reads
        rd(0, 0);
        check_eq("rcsr0_reset", bus_if.bus_rdata, 16'o000000);
        rd(0, 2);
        check_eq("xcsr0_reset", bus_if.bus_rdata, 16'o000200);
        cycle(1'b1, 1'b0, 22'o17777570, 16'h0000, '0, '0, '0, 1'b0);

        // TX fill with host stalled, fifth write dropped, then drain
        wr(0, 3, 16'h0041);
        check_eq("tx_valid0_first", host_tx_valid[0], 1'b1);
        check_eq("tx_data0_first", host_tx_data[7:0], 8'h41);
        for (int k = 1; k < 5; k++) wr(0, 3, 16'h0041 + 16'(k));
        rd(0, 2);
        check_eq("xcsr0_full", bus_if.bus_rdata, 16'o000000);
        for (int k = 0; k < 4; k++) begin
            check_eq("tx_drain_order", host_tx_data[7:0], 8'h41 + 8'(k));
            cycle(1'b0, 1'b0, 22'h0, 16'h0000, '0, '0, 2'b01, 1'b0);
        end
        check_eq("tx_valid0_drained", host_tx_valid[0], 1'b0);

        // RX fill on channel 1, read back in order, then empty
        for (int k = 0; k < 4; k++) begin
            vals[k] = 8'($urandom);
            hpush(1, vals[k]);
        end
        check_eq("rx_ready1_full", host_rx_ready[1], 1'b0);
        for (int k = 0; k < 4; k++) begin
            rd(1, 1);
            check_eq("rbuf1_order", bus_if.bus_rdata, {8'h00, vals[k]});
        end
        rd(1, 1);
        check_eq("rbuf1_empty", bus_if.bus_rdata, 16'h0000);
        rd(1, 0);
        check_eq("rcsr1_empty", bus_if.bus_rdata, 16'o000000);

        // Receive interrupt
        wr(0, 0, 16'o000100);
        check_eq("irq_rx0_empty", irq_rx[0], 1'b0);
        hpush(0, 8'h55);
        check_eq("irq_rx0_set", irq_rx[0], 1'b1);
        rd(0, 1);
        check_eq("rbuf0_55", bus_if.bus_rdata, 16'h0055);
        check_eq("irq_rx0_clr", irq_rx[0], 1'b0);

        // Fill, enable TX interrupts, then bus_init clears everything
        for (int k = 0; k < 4; k++) hpush(0, 8'($urandom));
        for (int k = 0; k < 4; k++) wr(1, 3, 16'($urandom));
        wr(0, 2, 16'o000100);
        check_eq("irq_tx0_set", irq_tx[0], 1'b1);
        wr(1, 2, 16'o000100);
        check_eq("irq_tx1_full", irq_tx[1], 1'b0);
        cycle(1'b0, 1'b0, 22'h0, 16'h0000, '0, '0, '0, 1'b1);
        check_eq("init_irq_tx", irq_tx, 2'b00);
        check_eq("init_irq_rx", irq_rx, 2'b00);
        check_eq("init_rx_ready", host_rx_ready, 2'b11);
        check_eq("init_tx_valid", host_tx_valid, 2'b00);
        rd(0, 0);
        check_eq("init_rcsr0", bus_if.bus_rdata, 16'o000000);
        rd(0, 2);
        check_eq("init_xcsr0", bus_if.bus_rdata, 16'o000200);

`ifdef DLART_MAINT_EN
        wr(0, 2, 16'o000004);
        wr(0, 3, 16'h007E);
        check_eq("maint_tx_valid", host_tx_valid[0], 1'b0);
        check_eq("maint_rx_ready", host_rx_ready[0], 1'b0);
        rd(0, 0);
        check_eq("maint_rcsr_done", bus_if.bus_rdata, 16'o000200);
        rd(0, 1);
        check_eq("maint_rbuf", bus_if.bus_rdata, 16'h007E);
        wr(0, 2, 16'o000000);
`endif

        // Randomized mixed traffic on both channels
        for (int n = 0; n < 800; n++) begin
            c = int'($urandom_range(0, NCH - 1));
            r = int'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) a = 22'($urandom);
            else a = base_of(c) + 22'(2 * r) + 22'($urandom_range(0, 1));
            cycle(1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)), a, 16'($urandom),
                  NCH'($urandom), (8*NCH)'($urandom), NCH'($urandom),
                  1'($urandom_range(0, 63) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
